// File: rtl/forward_ctrl_if.sv
// ---------------------------------------------------------------------------
// forward_ctrl_if
//
// Purpose : groups the decode-stage signals that the forwarding controller
//           consumes and the selects/stall it returns to decode.
//
// Signals : d_valid, d_rd, d_regwrite, d_ready_stage   decode instruction info
//           d_src0..d_src5, d_use                      decode source registers
//           hold, flush                                backend freeze / squash
//           forward0..forward5, stall                  controller outputs
//           stall_cycles, fwd_count                    counters (FWD_PERF_EN only)
//
// Modports: master = decode side (drives d_*, hold, flush)
//           slave  = forward_ctrl
//
// Optional: FWD_PERF_EN adds the two performance counter outputs.
// ---------------------------------------------------------------------------
interface forward_ctrl_if;
    logic       d_valid;
    logic [5:0] d_rd;
    logic       d_regwrite;
    logic [2:0] d_ready_stage;
    logic [5:0] d_src0;
    logic [5:0] d_src1;
    logic [5:0] d_src2;
    logic [5:0] d_src3;
    logic [5:0] d_src4;
    logic [5:0] d_src5;
    logic [5:0] d_use;
    logic       hold;
    logic       flush;
    logic [2:0] forward0;
    logic [2:0] forward1;
    logic [2:0] forward2;
    logic [2:0] forward3;
    logic [2:0] forward4;
    logic [2:0] forward5;
    logic       stall;
`ifdef FWD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] fwd_count;
`endif

    modport master (
        output d_valid, d_rd, d_regwrite, d_ready_stage,
        output d_src0, d_src1, d_src2, d_src3, d_src4, d_src5, d_use,
        output hold, flush,
        input  forward0, forward1, forward2, forward3, forward4, forward5,
        input  stall
`ifdef FWD_PERF_EN
        , input stall_cycles, fwd_count
`endif
    );

    modport slave (
        input  d_valid, d_rd, d_regwrite, d_ready_stage,
        input  d_src0, d_src1, d_src2, d_src3, d_src4, d_src5, d_use,
        input  hold, flush,
        output forward0, forward1, forward2, forward3, forward4, forward5,
        output stall
`ifdef FWD_PERF_EN
        , output stall_cycles, fwd_count
`endif
    );
endinterface

// File: rtl/forward_ctrl.sv
// ---------------------------------------------------------------------------
// forward_ctrl
//
// Purpose : tracks the destination registers of instructions in flight in
//           stages E, M, M2..M5 and, every cycle, resolves the decode-stage
//           sources against them: forwarding select per source plus the
//           load-use / long-latency stall.
//
// Ports   : clk   clock
//           rstn  asynchronous active-low reset
//           bus   forward_ctrl_if.slave (decode inputs, forward0..5, stall)
//
// Select encoding: 0=regfile, 1=E, 2=M, 3=M2, 4=M3, 5=M4, 6=M5.
//
// Optional: define FWD_PERF_EN to add stall_cycles / fwd_count counters.
// ---------------------------------------------------------------------------
module forward_ctrl (
    input  logic          clk,
    input  logic          rstn,
    forward_ctrl_if.slave bus
);
    localparam int NSTAGE = 6;
    localparam int NSRC   = 6;

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        logic [2:0] ready_stage;  // stage at whose output the result exists
    } entry_t;

    // Index 0 is the instruction in E (stage code 1), index 5 is M5.
    entry_t ent_q [NSTAGE];
    entry_t new_ent_d;

    logic [5:0]      src       [NSRC];
    logic [2:0]      fwd       [NSRC];
    logic [NSRC-1:0] not_ready;
    logic            stall;
    logic [2:0]      ready_clamped;

    assign src[0] = bus.d_src0;
    assign src[1] = bus.d_src1;
    assign src[2] = bus.d_src2;
    assign src[3] = bus.d_src3;
    assign src[4] = bus.d_src4;
    assign src[5] = bus.d_src5;

    // Resolve each source against the scoreboard. Walking from oldest to
    // youngest lets the last hit win, so the youngest producer is chosen
    // even when an older one already has its result.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            // NOTE: every output of this block gets a default first, so no
            // path leaves it unassigned and no latch is inferred.
            fwd[i]       = 3'd0;
            not_ready[i] = 1'b0;
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (bus.d_use[i] && ent_q[k].valid &&
                    ent_q[k].rd == src[i] && src[i] != 6'd0) begin
                    fwd[i]       = 3'(k + 1);
                    not_ready[i] = 3'(k + 1) < ent_q[k].ready_stage;
                end
            end
        end
    end

    // Flush squashes decode, so a squashed instruction never stalls.
    assign stall = bus.d_valid && !bus.flush && (|not_ready);

    // A ready stage of 0 means "immediately" (same as ALU); anything past
    // M5 is capped there since the result is written back after M5 anyway.
    always_comb begin
        ready_clamped = bus.d_ready_stage;
        if (bus.d_ready_stage == 3'd0)
            ready_clamped = 3'd1;
        else if (bus.d_ready_stage > 3'(NSTAGE))
            ready_clamped = 3'(NSTAGE);
    end

    // A stalled or flushed decode instruction leaves a bubble in E.
    always_comb begin
        new_ent_d.valid       = bus.d_valid && bus.d_regwrite && !stall && !bus.flush;
        new_ent_d.rd          = bus.d_rd;
        new_ent_d.ready_stage = ready_clamped;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, so every
            // entry is reset; the valid bits must be defined from reset.
            for (int k = 0; k < NSTAGE; k++)
                ent_q[k] <= '0;
        end else if (!bus.hold) begin
            // NOTE: non-blocking assignments make the shift read the old
            // value of each entry regardless of statement order.
            ent_q[0] <= new_ent_d;
            for (int k = 1; k < NSTAGE; k++)
                ent_q[k] <= ent_q[k-1];
        end
    end

    assign bus.forward0 = fwd[0];
    assign bus.forward1 = fwd[1];
    assign bus.forward2 = fwd[2];
    assign bus.forward3 = fwd[3];
    assign bus.forward4 = fwd[4];
    assign bus.forward5 = fwd[5];
    assign bus.stall    = stall;

`ifdef FWD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] fwd_count_q;
    logic [2:0]  nz_cnt;

    always_comb begin
        nz_cnt = 3'd0;
        for (int i = 0; i < NSRC; i++)
            nz_cnt = nz_cnt + {2'b00, (fwd[i] != 3'd0)};
    end

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= '0;
            fwd_count_q    <= '0;
        end else begin
            if (stall && !bus.hold)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (bus.d_valid && !stall && !bus.flush && !bus.hold)
                fwd_count_q <= fwd_count_q + {29'd0, nz_cnt};
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.fwd_count    = fwd_count_q;
`endif
endmodule

// File: tb/tb_forward_ctrl.sv
// ---------------------------------------------------------------------------
// tb_forward_ctrl
//
// Directed stimulus for forward_ctrl. The driver applies inputs just after
// each rising edge and queues the hand-computed expected outputs; a monitor
// on the falling edge pops the queue and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_forward_ctrl;
    logic clk = 1'b0;
    logic rstn;

    forward_ctrl_if bus ();

    forward_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] fwd;    // {forward5 .. forward0}
        logic [5:0]  dc;     // bit i set: forward i is don't-care
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation against the live outputs.
    exp_t        mon_e;
    logic [17:0] mon_act;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = {bus.forward5, bus.forward4, bus.forward3,
                       bus.forward2, bus.forward1, bus.forward0};
            for (int i = 0; i < 6; i++)
                if (!mon_e.dc[i])
                    check($sformatf("%s fwd%0d", mon_e.name, i),
                          32'(mon_act[3*i +: 3]), 32'(mon_e.fwd[3*i +: 3]));
            check($sformatf("%s stall", mon_e.name), 32'(bus.stall), 32'(mon_e.stall));
        end
    end

    task automatic drive(input logic v, input logic rw, input logic [5:0] rd,
                         input logic [2:0] rdy, input logic [5:0] s0,
                         input logic [5:0] s1, input logic [5:0] s5,
                         input logic [5:0] use_mask, input logic hld,
                         input logic fl);
        bus.d_valid       = v;
        bus.d_regwrite    = rw;
        bus.d_rd          = rd;
        bus.d_ready_stage = rdy;
        bus.d_src0        = s0;
        bus.d_src1        = s1;
        bus.d_src2        = 6'd0;
        bus.d_src3        = 6'd0;
        bus.d_src4        = 6'd0;
        bus.d_src5        = s5;
        bus.d_use         = use_mask;
        bus.hold          = hld;
        bus.flush         = fl;
    endtask

    task automatic expect_o(input string name, input logic [2:0] f0,
                            input logic [2:0] f1, input logic [2:0] f5,
                            input logic [5:0] dc, input logic st);
        exp_t e;
        e.name  = name;
        e.fwd   = {f5, 3'd0, 3'd0, 3'd0, f1, f0};
        e.dc    = dc;
        e.stall = st;
        sb_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 6'd0, 3'd1, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic drain;
        idle();
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        idle();
        #1;
        expect_o("reset", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();

        // ALU back-to-back, then follow the producer to retirement.
        drive(1, 1, 6'd5, 3'd1, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("alu_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd5, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("alu_e", 3'd1, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        expect_o("alu_m", 3'd2, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        for (int k = 3; k <= 6; k++) begin
            expect_o($sformatf("retire_k%0d", k), 3'(k), 3'd0, 3'd0, 6'd0, 1'b0);
            tick();
        end
        expect_o("retired", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drain();

        // Load-use: two stall cycles, two bubbles between load and consumer.
        drive(1, 1, 6'd7, 3'd3, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("ld_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 1, 6'd10, 3'd1, 6'd0, 6'd7, 6'd0, 6'b000010, 0, 0);
        expect_o("ld_use_k1", 3'd0, 3'd0, 3'd0, 6'b000010, 1'b1);
        tick();
        expect_o("ld_use_k2", 3'd0, 3'd0, 3'd0, 6'b000010, 1'b1);
        tick();
        expect_o("ld_use_fwd", 3'd0, 3'd3, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd10, 6'd7, 6'd0, 6'b000011, 0, 0);
        expect_o("ld_bubbles", 3'd1, 3'd4, 3'd0, 6'd0, 1'b0);
        tick();
        drain();

        // Youngest priority: unready load in E shadows ready producer in M4.
        drive(1, 1, 6'd9, 3'd1, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("yp_issue_alu", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        idle();
        repeat (3) tick();
        drive(1, 1, 6'd9, 3'd3, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("yp_issue_ld", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd9, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("yp_stall_k1", 3'd0, 3'd0, 3'd0, 6'b000001, 1'b1);
        tick();
        expect_o("yp_stall_k2", 3'd0, 3'd0, 3'd0, 6'b000001, 1'b1);
        tick();
        expect_o("yp_fwd", 3'd3, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drain();

        // x0 never forwards, f0 (32) does; reg5 port exercised too.
        drive(1, 1, 6'd0, 3'd1, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("x0_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 1, 6'd32, 3'd1, 6'd0, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("x0_e", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd0, 6'd32, 6'd32, 6'b100011, 0, 0);
        expect_o("x0_f0", 3'd0, 3'd1, 3'd1, 6'd0, 1'b0);
        tick();
        drain();

        // Hold freezes the scoreboard and blocks insertion.
        drive(1, 1, 6'd4, 3'd1, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("hold_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        idle();
        tick();
        drive(1, 1, 6'd4, 3'd1, 6'd4, 6'd0, 6'd0, 6'b000001, 1, 0);
        for (int c = 0; c < 3; c++) begin
            expect_o($sformatf("hold_%0d", c), 3'd2, 3'd0, 3'd0, 6'd0, 1'b0);
            tick();
        end
        drive(1, 0, 6'd0, 3'd1, 6'd4, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("hold_release", 3'd2, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        expect_o("hold_shift", 3'd3, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drain();

        // Flush beats stall and leaves a bubble in E.
        drive(1, 1, 6'd7, 3'd3, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("fl_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 1, 6'd11, 3'd1, 6'd7, 6'd0, 6'd0, 6'b000001, 0, 1);
        expect_o("flush_stall", 3'd0, 3'd0, 3'd0, 6'b000001, 1'b0);
        tick();
        drive(0, 0, 6'd0, 3'd1, 6'd11, 6'd7, 6'd0, 6'b000011, 0, 0);
        expect_o("flush_bubble", 3'd0, 3'd0, 3'd0, 6'b000010, 1'b0);
        tick();
        drain();

        // Ready stage clamping: 0 behaves as 1, 7 behaves as 6.
        drive(1, 1, 6'd12, 3'd0, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("clamp_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 1, 6'd13, 3'd7, 6'd12, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("clamp0", 3'd1, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd13, 6'd0, 6'd0, 6'b000001, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            expect_o($sformatf("clamp7_k%0d", k), 3'd0, 3'd0, 3'd0, 6'b000001, 1'b1);
            tick();
        end
        expect_o("clamp7_ready", 3'd6, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drain();

        // Reset mid-stream clears the scoreboard immediately.
        drive(1, 1, 6'd20, 3'd3, 6'd0, 6'd0, 6'd0, 6'b000000, 0, 0);
        expect_o("rst_issue", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        drive(1, 0, 6'd0, 3'd1, 6'd20, 6'd0, 6'd0, 6'b000001, 0, 0);
        expect_o("rst_pre", 3'd0, 3'd0, 3'd0, 6'b000001, 1'b1);
        tick();
        rstn = 1'b0;
        expect_o("rst_async", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();
        rstn = 1'b1;
        expect_o("rst_release", 3'd0, 3'd0, 3'd0, 6'd0, 1'b0);
        tick();

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
